sync_fifo_prog: RTL
===================

// Module: sync_fifo_prog
// PURPOSE
//  Parametrised synchronous FIFO, next generation of the team's 16x8 FIFO.
//  Adds any-integer depth, programmable almost-full/almost-empty thresholds,
//  an occupancy count and a selectable first-word-fall-through (FWFT) read mode.
//  Sits between a producer and a consumer in the same clock domain. It is driven
//  and monitored by the FIFO agent through the existing fifo_if signal set.
// PARAMETERS
//  FifoWidth   16  data word width in bits (>=1)
//  FifoDepth   8   number of entries; any integer >=2, not restricted to powers of 2
//  FwftMode    0   0 = standard registered read; 1 = first-word-fall-through
//  CntW        $clog2(FifoDepth+1)  localparam; width of count and threshold ports
// PORTS
//  clk_i          in   1          clock; all logic on posedge
//  rst_i          in   1          synchronous reset, active-high
//  data_in        in   FifoWidth  write data
//  wr_en          in   1          write request
//  rd_en          in   1          read request (pop, in FWFT mode)
//  afull_thresh   in   CntW       almostfull threshold; 0 disables almostfull
//  aempty_thresh  in   CntW       almostempty threshold
//  data_out       out  FifoWidth  read data
//  valid          out  1          data_out is valid this cycle
//  wr_ack         out  1          previous-cycle write was accepted
//  overflow       out  1          previous-cycle write was rejected
//  underflow      out  1          previous-cycle read was rejected
//  full           out  1          count == FifoDepth
//  empty          out  1          count == 0
//  almostfull     out  1          afull_thresh!=0 && count >= afull_thresh
//  almostempty    out  1          count <= aempty_thresh
//  count          out  CntW       current occupancy, 0..FifoDepth
// BEHAVIOUR
//  Reset: rst_i high at a posedge clears wr_ptr, rd_ptr and count to 0.
//   Resulting outputs: data_out=0, valid=0, wr_ack=0, overflow=0, underflow=0,
//   full=0, empty=1, almostempty=1, almostfull=0. Memory is not cleared.
//   Reset mid-operation discards all contents. A write in the first cycle after
//   release is accepted.
//  Flags: full, empty, almostfull and almostempty decode combinationally from the
//   registered count and the live thresholds. A threshold change takes effect in
//   the same cycle.
//  Handshake: wr_fire = wr_en && (!full || rd_fire); rd_fire = rd_en && !empty.
//   - Full with wr_en and rd_en both high: both accepted; count and full unchanged.
//   - Empty with wr_en and rd_en both high: write accepted, read rejected.
//  Count update, registered: +1 on wr_fire only; -1 on rd_fire only; unchanged
//   when both or neither fire.
//  Pointer update: each pointer increments on its fire and wraps from FifoDepth-1
//   to 0. No power-of-2 wrap is assumed.
//  Status outputs, all registered one-cycle pulses:
//   - wr_ack <= wr_fire
//   - overflow <= wr_en && !wr_fire
//   - underflow <= rd_en && !rd_fire
//  FwftMode=0: on rd_fire, data_out <= mem[rd_ptr], giving 1-cycle latency.
//   valid pulses for that one cycle. data_out holds its value otherwise,
//   including on underflow.
//  FwftMode=1: data_out = mem[rd_ptr] (combinational) and valid = !empty.
//   A write into an empty FIFO appears on data_out the next cycle.
//   rd_en acknowledges and pops the head.
//  Same-cycle read and write at the same address cannot occur, except when
//   full. In that case the read returns the old word.
// CONFIGURATION
//  FIFO_STICKY_ERR_EN defined:
//   - Adds port err_clr (in, 1).
//   - overflow and underflow become sticky: set by their event, held until a
//     cycle with err_clr=1.
//   - An event in the same cycle as err_clr leaves the flag set.
//   - Reset clears both flags.
//  FIFO_STICKY_ERR_EN undefined: err_clr does not exist; overflow and underflow
//   are single-cycle pulses as described in BEHAVIOUR.
// TESTING  (FifoWidth=16, FifoDepth=8 unless stated)
//  1. Reset, then write 0x0001..0x0008 on consecutive cycles -> wr_ack each cycle
//     after, count=8, full=1. A 9th write -> overflow=1 for one cycle, count stays 8.
//  2. FwftMode=0, 8 reads from full -> data_out 0x0001..0x0008, each one cycle
//     after rd_en, then empty=1. A 9th rd_en -> underflow=1 for one cycle,
//     data_out holds 0x0008.
//  3. Full, then wr_en=rd_en=1 for 4 cycles with 0x00A0..0x00A3 -> count=8 and
//     full=1 throughout. Draining yields 0x0005..0x0008 then 0x00A0..0x00A3.
//  4. afull_thresh=6, aempty_thresh=2, writes from empty -> almostempty=1 at
//     count 2 and 0 at count 3; almostfull=1 at count 6. Setting afull_thresh=0
//     -> almostfull=0 in the same cycle.
//  5. FifoDepth=5: write 5, read 3, write 3 -> count=5, full=1. Drain order is
//     w4,w5,w6,w7,w8 across the pointer wrap.
//  6. FwftMode=1: write 0xABCD into empty -> next cycle valid=1 and
//     data_out=0xABCD with no rd_en. Pulse rd_en -> empty=1 and valid=0 next cycle.
//     Assert rst_i with 3 words held -> count=0, empty=1.

Source files
------------

// File: rtl/sync_fifo_prog.sv
// Parametrised synchronous FIFO with any-integer depth, programmable
// almost-full/almost-empty thresholds, occupancy count and an optional
// first-word-fall-through read mode.
// Optional feature macro: FIFO_STICKY_ERR_EN adds err_clr and makes
// overflow/underflow sticky until cleared.
module sync_fifo_prog #(
  parameter int unsigned FifoWidth = 16,
  parameter int unsigned FifoDepth = 8,
  parameter bit          FwftMode  = 1'b0,
  localparam int unsigned CntW     = $clog2(FifoDepth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
`ifdef FIFO_STICKY_ERR_EN
  input  logic                 err_clr,
`endif
  input  logic [FifoWidth-1:0] data_in,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [CntW-1:0]      afull_thresh,
  input  logic [CntW-1:0]      aempty_thresh,
  output logic [FifoWidth-1:0] data_out,
  output logic                 valid,
  output logic                 wr_ack,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 full,
  output logic                 empty,
  output logic                 almostfull,
  output logic                 almostempty,
  output logic [CntW-1:0]      count
);

  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(FifoDepth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(FifoDepth);

  logic [FifoWidth-1:0] mem [FifoDepth];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q;
  logic                 wr_ack_q, overflow_q, underflow_q;
  logic                 wr_fire, rd_fire, ovf_evt, udf_evt;

  // Flags decode from the registered count and the live thresholds.
  always_comb begin
    full        = (count_q == DepthCnt);
    empty       = (count_q == '0);
    almostfull  = (afull_thresh != '0) && (count_q >= afull_thresh);
    almostempty = (count_q <= aempty_thresh);
    // A full FIFO still accepts a write when a read frees a slot the same cycle.
    rd_fire     = rd_en && !empty;
    wr_fire     = wr_en && (!full || rd_fire);
    ovf_evt     = wr_en && !wr_fire;
    udf_evt     = rd_en && !rd_fire;
  end

  // Pointers and occupancy; pointers wrap explicitly at FifoDepth-1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_fire) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      if (rd_fire) rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      unique case ({wr_fire, rd_fire})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array, deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_fire) mem[wr_ptr_q] <= data_in;
  end

  // Status pulses (or sticky error flags when enabled).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ack_q    <= wr_fire;
`ifdef FIFO_STICKY_ERR_EN
      // An event coinciding with err_clr wins so it is never lost.
      overflow_q  <= (overflow_q  && !err_clr) || ovf_evt;
      underflow_q <= (underflow_q && !err_clr) || udf_evt;
`else
      overflow_q  <= ovf_evt;
      underflow_q <= udf_evt;
`endif
    end
  end

  assign wr_ack    = wr_ack_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign count     = count_q;

  if (FwftMode) begin : g_fwft
    // Head word is exposed directly; forced to zero when empty so stale or
    // uninitialised storage never shows on the bus.
    always_comb begin
      valid    = !empty;
      data_out = empty ? '0 : mem[rd_ptr_q];
    end
  end else begin : g_std
    logic [FifoWidth-1:0] data_q;
    logic                 valid_q;

    // Registered read: data appears one cycle after an accepted rd_en and holds.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_fire;
        if (rd_fire) data_q <= mem[rd_ptr_q];
      end
    end

    assign data_out = data_q;
    assign valid    = valid_q;
  end

endmodule
